lelbc_round: RTL and testbench
==============================

# lelbc_round

Single registered round of the LELBC 64-bit lightweight block cipher (128-bit key), following the PRESENT-128 SPN structure. It takes the current cipher state, current round key and a 5-bit round index, and produces the next state and next round key one cycle later. An iterative encryption controller instantiates it and loops its outputs back for 16 rounds (round index 0..15).

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clk  input  1  — rising-edge clock; the design's only clock.
- rst_n  input  1  — reset; asynchronous, active-low.
- valid_in  input  1  — the input fields are valid this cycle.
- state_in  input  64 [0:63]  — cipher state; bit 0 is the MSB.
- key_in  input  128 [0:127]  — current round key; bit 0 is the MSB.
- round  input  5 [0:4]  — round index, 0..31.
- valid_out  output  1  — the output fields hold a fresh result.
- state_out  output  64 [0:63]  — next cipher state.
- key_out  output  128 [0:127]  — next round key.

## Operation
Data path (all indices MSB-first, bit 0 = MSB):
- AddRoundKey: x = state_in ^ key_in[0:63].
- S-box layer: 16 parallel 4-bit S-boxes, one per nibble x[4j:4j+3].
  - S-box as hex, input 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Permutation layer: bit i moves to position 16*i mod 63 for i = 0..62; bit 63 stays at 63.
- state_out is the permuted value.

Key schedule, applied to key_in:
- Rotate left by 61: k = {key_in[61:127], key_in[0:60]}.
- Substitute nibble k[0:3] through the S-box, then nibble k[4:7].
- XOR the round index into bits: k[61:65] ^= round[0:4].
- key_out = k.

Other rules:
- The round index is used as-is; the caller maps its counter to a round number.
- All 32 round values are legal.
- The block has no internal state other than the output registers.

## Timing
- Latency is 1 cycle. Inputs sampled at a clk rise with valid_in=1 appear on state_out/key_out after that edge, with valid_out=1.
- Throughput is one round per cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- If valid_in=0 at a clock edge:
  - valid_out goes to 0 after that edge.
  - state_out and key_out hold their previous values.
- No backpressure: the consumer must take the result in the cycle valid_out=1.
- Reset, while rst_n=0 and effective immediately (asynchronous): valid_out=0, state_out=0, key_out=0.
- Reset during operation discards any in-flight result. The first valid output after reset release comes one cycle after the first sampled valid_in=1.

## Configuration
- LELBC_RF_COMB_EN defined: the round is purely combinational.
  - state_out and key_out follow the inputs in the same cycle.
  - valid_out = valid_in.
  - clk and rst_n stay in the port list but are unused.
  - This mode serves controllers that register the loop themselves.
- LELBC_RF_COMB_EN not defined (default): registered behaviour as described in Timing.

## Test plan
- Zero vector: state_in=0, key_in=0, round=0, valid_in=1 → next cycle:
  - state_out=0xFFFFFFFF00000000
  - key_out=0xCC000000000000000000000000000000
  - valid_out=1
- Round constant: state_in=0, key_in=0, round=1 → key_out=0xCC000000000000004000000000000000; state_out=0xFFFFFFFF00000000.
- All-ones state: state_in=0xFFFFFFFFFFFFFFFF, key_in=0, round=0 → state_out=0x00000000FFFF0000.
- Key cancels state: state_in=0x0123456789ABCDEF, key_in[0:63]=0x0123456789ABCDEF, key_in[64:127]=0, round=0 → state_out=0xFFFFFFFF00000000.
- Handshake/hold:
  - Two back-to-back valid vectors → two consecutive valid_out=1 cycles with the matching results.
  - Then valid_in=0 → valid_out=0; outputs hold the last result.
- Asynchronous reset: assert rst_n=0 mid-stream between clock edges → valid_out, state_out and key_out read 0 immediately. After release, outputs stay 0 until a valid input is sampled.

Source files
------------

// File: rtl/lelbc_round.sv
`default_nettype none
// ============================================================================
// Module   : lelbc_round
// Purpose  : One registered LELBC (PRESENT-128 style) round with key schedule.
//            Define LELBC_RF_COMB_EN for a purely combinational round.
// Revision : 1.0 - initial release
// ============================================================================
module lelbc_round (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    input  logic [63:0]  state_in,
    input  logic [127:0] key_in,
    input  logic [4:0]   round,
    output logic         valid_out,
    output logic [63:0]  state_out,
    output logic [127:0] key_out
);

    // Vectors are held descending; MSB-first bit i of the cipher lives at [W-1-i].
    localparam int unsigned C_SW = 64;
    localparam int unsigned C_KW = 128;

    function automatic logic [3:0] f_sbox(input logic [3:0] v);
        logic [3:0] s;
        case (v)
            4'h0: s = 4'hC;
            4'h1: s = 4'h5;
            4'h2: s = 4'h6;
            4'h3: s = 4'hB;
            4'h4: s = 4'h9;
            4'h5: s = 4'h0;
            4'h6: s = 4'hA;
            4'h7: s = 4'hD;
            4'h8: s = 4'h3;
            4'h9: s = 4'hE;
            4'hA: s = 4'hF;
            4'hB: s = 4'h8;
            4'hC: s = 4'h4;
            4'hD: s = 4'h7;
            4'hE: s = 4'h1;
            default: s = 4'h2;
        endcase
        return s;
    endfunction

    logic [63:0]  w_ark;
    logic [63:0]  w_sub;
    logic [63:0]  w_perm;
    logic [127:0] w_rot;
    logic [127:0] w_key_next;

    assign w_ark = state_in ^ key_in[C_KW-1 -: C_SW];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sbox
            assign w_sub[C_SW-1-4*gi -: 4] = f_sbox(w_ark[C_SW-1-4*gi -: 4]);
        end
        for (gi = 0; gi < 63; gi++) begin : g_perm
            assign w_perm[C_SW-1-((16*gi) % 63)] = w_sub[C_SW-1-gi];
        end
    endgenerate

    assign w_perm[0] = w_sub[0];

    // Key rotation by 61 toward the MSB, then top two nibbles through the S-box.
    assign w_rot = {key_in[66:0], key_in[127:67]};

    always_comb begin
        w_key_next          = w_rot;
        w_key_next[127:124] = f_sbox(w_rot[127:124]);
        w_key_next[123:120] = f_sbox(w_rot[123:120]);
        w_key_next[66:62]   = w_rot[66:62] ^ round;
    end

`ifdef LELBC_RF_COMB_EN
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    assign valid_out = valid_in;
    assign state_out = w_perm;
    assign key_out   = w_key_next;
`else
    logic         r_valid;
    logic [63:0]  r_state;
    logic [127:0] r_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_state <= '0;
            r_key   <= '0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_state <= w_perm;
                r_key   <= w_key_next;
            end
        end
    end

    assign valid_out = r_valid;
    assign state_out = r_state;
    assign key_out   = r_key;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lelbc_round.sv
`default_nettype none
// Testbench for lelbc_round: vector table plus queue scoreboard, hold and async reset sequences.
module tb_lelbc_round;

    logic         clk;
    logic         rst_n;
    logic         valid_in;
    logic [63:0]  state_in;
    logic [127:0] key_in;
    logic [4:0]   round;
    logic         valid_out;
    logic [63:0]  state_out;
    logic [127:0] key_out;

    lelbc_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .state_in  (state_in),
        .key_in    (key_in),
        .round     (round),
        .valid_out (valid_out),
        .state_out (state_out),
        .key_out   (key_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  s;
        logic [127:0] k;
    } res_t;

    typedef struct {
        logic [63:0]  st;
        logic [127:0] ky;
        logic [4:0]   rd;
        logic [63:0]  exp_s;
        logic [127:0] exp_k;
    } vec_t;

    int   checks;
    int   failures;
    res_t q[$];
    res_t last;
    bit   chk_en;

    logic [3:0] sb_tab [16];
    initial begin
        sb_tab = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                   4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    end

    // Reference round written in LSB-indexed PRESENT form.
    function automatic res_t model(input logic [63:0] s, input logic [127:0] k, input logic [4:0] r);
        res_t        o;
        logic [63:0] x;
        logic [63:0] y;
        logic [127:0] kk;
        x = s ^ k[127:64];
        for (int j = 0; j < 16; j++) y[4*j +: 4] = sb_tab[x[4*j +: 4]];
        o.s = '0;
        for (int i = 0; i < 63; i++) o.s[(16*i) % 63] = y[i];
        o.s[63] = y[63];
        kk = {k[66:0], k[127:67]};
        kk[127:124] = sb_tab[kk[127:124]];
        kk[123:120] = sb_tab[kk[123:120]];
        kk[66:62]   = kk[66:62] ^ r;
        o.k = kk;
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] s, input logic [127:0] k,
                         input logic [4:0] r, input res_t e);
        @(negedge clk);
        valid_in = v;
        state_in = s;
        key_in   = k;
        round    = r;
        if (v) q.push_back(e);
    endtask

    task automatic idle();
        res_t z;
        z.s = '0;
        z.k = '0;
        drive(1'b0, $urandom() == 0 ? 64'h0 : {$urandom(), $urandom()}, '0, 5'd0, z);
    endtask

    // Scoreboard: a valid sample pops the next expectation, otherwise outputs must hold.
    initial begin
        logic v;
        bit   en;
        forever begin
            @(posedge clk);
            v  = valid_in;
            en = chk_en && rst_n;
            #1;
            if (en) begin
                if (v) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_underflow: got empty queue expected entry");
                    end else begin
                        last = q.pop_front();
                    end
                end
                check("valid_out", {127'd0, valid_out}, {127'd0, v});
                check("state_out", {64'd0, state_out}, {64'd0, last.s});
                check("key_out", key_out, last.k);
            end
        end
    end

    vec_t vecs[10];

    initial begin
        res_t m;
        checks   = 0;
        failures = 0;
        chk_en   = 0;
        last.s   = '0;
        last.k   = '0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        state_in = '0;
        key_in   = '0;
        round    = '0;

        vecs[0] = '{64'h0, 128'h0, 5'd0, 64'hFFFFFFFF00000000,
                    128'hCC000000000000000000000000000000};
        vecs[1] = '{64'h0, 128'h0, 5'd1, 64'hFFFFFFFF00000000,
                    128'hCC000000000000004000000000000000};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 128'h0, 5'd0, 64'h00000000FFFF0000,
                    128'hCC000000000000000000000000000000};
        m = model(64'h0123456789ABCDEF, {64'h0123456789ABCDEF, 64'h0}, 5'd0);
        vecs[3] = '{64'h0123456789ABCDEF, {64'h0123456789ABCDEF, 64'h0}, 5'd0,
                    64'hFFFFFFFF00000000, m.k};
        for (int i = 4; i < 10; i++) begin
            vecs[i].st = {$urandom(), $urandom()};
            vecs[i].ky = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].rd = (i == 9) ? 5'd31 : 5'($urandom_range(0, 31));
            m = model(vecs[i].st, vecs[i].ky, vecs[i].rd);
            vecs[i].exp_s = m.s;
            vecs[i].exp_k = m.k;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {127'd0, valid_out}, 128'd0);
        check("reset_state", {64'd0, state_out}, 128'd0);
        check("reset_key", key_out, 128'd0);

        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1;

        // Table applied back to back
        for (int i = 0; i < 10; i++) begin
            res_t e;
            e.s = vecs[i].exp_s;
            e.k = vecs[i].exp_k;
            drive(1'b1, vecs[i].st, vecs[i].ky, vecs[i].rd, e);
        end
        idle();
        idle();

        // Two more back-to-back, then hold
        for (int i = 0; i < 2; i++) begin
            logic [63:0]  s;
            logic [127:0] k;
            logic [4:0]   r;
            s = {$urandom(), $urandom()};
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            r = 5'($urandom_range(0, 31));
            drive(1'b1, s, k, r, model(s, k, r));
        end
        idle();
        idle();

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        chk_en = 0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_valid", {127'd0, valid_out}, 128'd0);
        check("async_rst_state", {64'd0, state_out}, 128'd0);
        check("async_rst_key", key_out, 128'd0);
        q.delete();
        last.s = '0;
        last.k = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1;
        idle();
        idle();
        idle();
        drive(1'b1, 64'hFEDCBA9876543210, 128'h00112233445566778899AABBCCDDEEFF, 5'd7,
              model(64'hFEDCBA9876543210, 128'h00112233445566778899AABBCCDDEEFF, 5'd7));
        idle();
        idle();
        @(negedge clk);
        check("scoreboard_drained", 128'(q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
